// File: rtl/lsu_pkg.sv
// lsu_pkg: FSM states, funct3 codes and access-size decode shared by the load/store unit.
// The BEAT1 state exists only when LSU_MISALIGNED_EN is defined.
package lsu_pkg;
   typedef enum logic [1:0] {
      IDLE,
      BEAT0,
`ifdef LSU_MISALIGNED_EN
      BEAT1,
`endif
      RESP
   } state_e;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;
   function automatic logic [3:0] lsu_size(input logic [1:0] w);
      return 4'd1 << w;
   endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: request, memory-beat and response signals of the load/store unit.
interface lsu_if #(
   parameter int XLEN = 32
) ();
   localparam int NB = XLEN / 8;
   logic            req_valid, req_ready, req_store;
   logic [2:0]      req_funct3;
   logic [XLEN-1:0] req_addr, req_wdata;
   logic            mem_valid, mem_ready, mem_we;
   logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
   logic [NB-1:0]   mem_wmask;
   logic            rsp_valid, rsp_err;
   logic [XLEN-1:0] rsp_data;
   modport slave (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
      output req_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask, rsp_valid, rsp_err, rsp_data
   );
   modport master (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
      input  req_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask, rsp_valid, rsp_err, rsp_data
   );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: lane positioning of store data/mask and extraction plus extension of load data.
module lsu_align import lsu_pkg::*; #(
   parameter int XLEN = 32,
   parameter int WIN  = 64
) (
   input  logic [2:0]               funct3_i,
   input  logic [$clog2(XLEN/8)-1:0] off_i,
   input  logic [XLEN-1:0]          wdata_i,
   input  logic [WIN-1:0]           rwin_i,
   output logic [WIN-1:0]           wwin_o,
   output logic [WIN/8-1:0]         wmask_o,
   output logic [XLEN-1:0]          rdata_o
);
   localparam int WNB = WIN / 8;
   logic [3:0]      size;
   logic [XLEN-1:0] shifted, keep, low;
   logic            sign;
   always_comb begin
      size    = lsu_size(funct3_i[1:0]);
      wwin_o  = WIN'(wdata_i) << {off_i, 3'b000};
      wmask_o = WNB'((1 << size) - 1) << off_i;
      shifted = XLEN'(rwin_i >> {off_i, 3'b000});
      keep    = {XLEN{1'b1}} >> (XLEN - 8 * int'(size));
      low     = shifted & keep;
      // sign bit is the top kept bit
      sign    = !funct3_i[2] && |(low & ~(keep >> 1));
      rdata_o = low | (sign ? ~keep : '0);
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns one load/store request into one or two word beats and a response pulse.
// Define LSU_MISALIGNED_EN to split word-crossing accesses instead of rejecting misaligned ones.
module load_store_unit import lsu_pkg::*; #(
   parameter int XLEN = 32
) (
   input logic   clk,
   input logic   reset,
   lsu_if.slave  bus
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);
`ifdef LSU_MISALIGNED_EN
   localparam int WIN = 2 * XLEN;
`else
   localparam int WIN = XLEN;
`endif
   localparam int WNB = WIN / 8;
   state_e          state_q, state_d;
   logic            store_q, err_q, req_err, beat_hi;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] addr_q, wdata_q, ldata;
   logic [WIN-1:0]  rwin_q, wwin;
   logic [WNB-1:0]  wmask;
`ifdef LSU_MISALIGNED_EN
   logic cross;
   assign cross = int'(addr_q[OW-1:0]) + int'(lsu_size(f3_q[1:0])) > NB;
`else
   logic [3:0] rsz;
   assign rsz = lsu_size(bus.req_funct3[1:0]);
`endif
   always_comb begin
      req_err = bus.req_store
              ? (bus.req_funct3[2] || (XLEN == 32 && bus.req_funct3 == F3_D))
              : (bus.req_funct3 == 3'b111 || (XLEN == 32 && (bus.req_funct3 == F3_D || bus.req_funct3 == F3_WU)));
`ifndef LSU_MISALIGNED_EN
      req_err = req_err || (bus.req_addr[OW-1:0] & (rsz[OW-1:0] - OW'(1))) != '0;
`endif
   end
   lsu_align #(.XLEN(XLEN), .WIN(WIN)) u_align (
      .funct3_i (f3_q),
      .off_i    (addr_q[OW-1:0]),
      .wdata_i  (wdata_q),
      .rwin_i   (rwin_q),
      .wwin_o   (wwin),
      .wmask_o  (wmask),
      .rdata_o  (ldata)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = bus.req_valid ? (req_err ? RESP : BEAT0) : IDLE;
`ifdef LSU_MISALIGNED_EN
         BEAT0:   state_d = bus.mem_ready ? (cross ? BEAT1 : RESP) : BEAT0;
         BEAT1:   state_d = bus.mem_ready ? RESP : BEAT1;
`else
         BEAT0:   state_d = bus.mem_ready ? RESP : BEAT0;
`endif
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      beat_hi = 1'b0;
`ifdef LSU_MISALIGNED_EN
      beat_hi = state_q == BEAT1;
`endif
      bus.req_ready = state_q == IDLE;
      bus.mem_valid = state_q == BEAT0 || beat_hi;
      bus.mem_we    = bus.mem_valid && store_q;
      bus.mem_addr  = bus.mem_valid ? {addr_q[XLEN-1:OW], OW'(0)} + (beat_hi ? XLEN'(NB) : '0) : '0;
      bus.mem_wdata = bus.mem_we ? (beat_hi ? wwin[WIN-1 -: XLEN] : wwin[XLEN-1:0]) : '0;
      bus.mem_wmask = bus.mem_we ? (beat_hi ? wmask[WNB-1 -: NB] : wmask[NB-1:0]) : '0;
      bus.rsp_valid = state_q == RESP;
      bus.rsp_err   = bus.rsp_valid && err_q;
      bus.rsp_data  = bus.rsp_valid && !err_q && !store_q ? ldata : '0;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         store_q <= 1'b0;
         err_q   <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rwin_q  <= '0;
      end else begin
         if (state_q == IDLE && bus.req_valid) begin
            store_q <= bus.req_store;
            err_q   <= req_err;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end
         if (state_q == BEAT0 && bus.mem_ready) rwin_q[XLEN-1:0] <= bus.mem_rdata;
`ifdef LSU_MISALIGNED_EN
         if (beat_hi && bus.mem_ready) rwin_q[WIN-1 -: XLEN] <= bus.mem_rdata;
`endif
      end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: byte-level reference model of the LSU, directed pins plus randomized traffic.
module tb_load_store_unit;
   localparam int XLEN = 32;
   localparam int NB   = 4;
`ifdef LSU_MISALIGNED_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   lsu_if #(.XLEN(XLEN)) bus ();
   load_store_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));
   int tests = 0, fails = 0;
   logic [31:0] mem_word [logic [31:0]];
   int mem_mode = 0;
   logic pending = 1'b0, e_err, e_store;
   logic [31:0] e_data, e_addr, e_wdata, ba;
   int e_size, e_off, e_beats, beats_seen, li, last_beats;
   time acc_t;
   logic [31:0] last_data, last_wdata;
   logic [3:0] last_mask;
   logic last_err;
   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction
   function automatic logic [31:0] rd(logic [31:0] w);
      return mem_word.exists(w) ? mem_word[w] : (w * 32'h9E3779B1) ^ 32'hA5C30F17;
   endfunction
   // memory: 0 = always ready, 1 = random wait states, 2 = never ready
   always @(posedge clk) begin
      #2;
      bus.mem_ready = mem_mode == 0 ? 1'b1 : mem_mode == 1 ? ($urandom_range(0, 2) == 0) : 1'b0;
      bus.mem_rdata = bus.mem_ready ? rd(bus.mem_addr) : $urandom;
   end
   always @(negedge clk) if (reset) begin
      if (bus.mem_valid) begin
         if (!pending || e_err) chk("beat_not_expected", bus.mem_valid, 1'b0);
         else begin
            ba = e_addr - 32'(e_off) + 32'(beats_seen * NB);
            chk("beat_addr", bus.mem_addr, ba);
            chk("beat_we", bus.mem_we, e_store);
            if (e_store) begin
               for (int l = 0; l < NB; l++) begin
                  li = beats_seen * NB + l - e_off;
                  chk("wmask_lane", bus.mem_wmask[l], li >= 0 && li < e_size);
                  if (li >= 0 && li < e_size) chk("wdata_lane", bus.mem_wdata[8*l +: 8], e_wdata[8*li +: 8]);
               end
            end else chk("read_wmask", bus.mem_wmask, 4'b0);
            if (bus.mem_ready) begin
               beats_seen++;
               last_wdata = bus.mem_wdata;
               last_mask  = bus.mem_wmask;
            end
         end
      end
      if (bus.rsp_valid) begin
         if (!pending) chk("rsp_not_expected", bus.rsp_valid, 1'b0);
         else begin
            chk("rsp_err", bus.rsp_err, e_err);
            if (!e_err) chk("rsp_data", bus.rsp_data, e_data);
            chk("beat_count", beats_seen, e_beats);
            // edges from the accept edge: 1 aligned (3rd cycle), 2 split (4th cycle)
            if (mem_mode == 0 && !e_err) chk("latency", int'(($time - acc_t - 5) / 10), e_beats);
            last_data  = bus.rsp_data;
            last_err   = bus.rsp_err;
            last_beats = beats_seen;
            pending    = 1'b0;
         end
         chk("ready_in_rsp", bus.req_ready, 1'b0);
      end else chk("req_ready", bus.req_ready, !pending);
   end
   task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      int sz = 1 << f3[1:0];
      logic legal = st ? (f3 < 3'd3) : (f3 != 3'd3 && f3 < 3'd6);
      logic [31:0] v = '0;
      logic [31:0] b;
      e_err   = !legal || (!MIS && (a % sz) != 0);
      e_off   = int'(a % NB);
      e_beats = e_err ? 0 : (e_off + sz > NB ? 2 : 1);
      if (!e_err && !st) begin
         for (int i = 0; i < sz; i++) begin
            b = a + 32'(i);
            v |= ((rd(b & ~32'd3) >> (8 * (b % NB))) & 32'hFF) << (8 * i);
         end
         if (!f3[2] && sz < NB && v[8*sz-1]) v |= 32'hFFFFFFFF << (8 * sz);
      end
      e_data = (st || e_err) ? '0 : v;
      @(negedge clk);
      for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
      chk("ready_before_send", bus.req_ready, 1'b1);
      bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
      @(posedge clk);
      acc_t = $time; e_store = st; e_addr = a; e_wdata = wd; e_size = sz; beats_seen = 0; pending = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0; bus.req_store = 1'($urandom); bus.req_funct3 = 3'($urandom);
      bus.req_addr = $urandom; bus.req_wdata = $urandom;
   endtask
   task automatic finish_txn();
      for (int i = 0; i < 300 && pending; i++) @(negedge clk);
      chk("rsp_timeout", pending, 1'b0);
      pending = 1'b0;
      @(negedge clk);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = '0; bus.req_addr = '0; bus.req_wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 1'b1);
      chk("rst_mem_valid", bus.mem_valid, 1'b0);
      chk("rst_mem_we", bus.mem_we, 1'b0);
      chk("rst_mem_wmask", bus.mem_wmask, 4'b0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 34'h0);
      reset = 1'b1;
      @(negedge clk);
      mem_word[32'h100] = 32'hDEADBEEF;
      send(1'b0, 3'b010, 32'h100, 32'h0); finish_txn();
      chk("lw_data", last_data, 32'hDEADBEEF);
      chk("lw_beats", last_beats, 1);
      mem_word[32'h100] = 32'h80112233;
      send(1'b0, 3'b000, 32'h103, 32'h0); finish_txn();
      chk("lb_data", last_data, 32'hFFFFFF80);
      send(1'b0, 3'b100, 32'h103, 32'h0); finish_txn();
      chk("lbu_data", last_data, 32'h00000080);
      send(1'b1, 3'b001, 32'h102, 32'h0000ABCD); finish_txn();
      chk("sh_mask", last_mask, 4'b1100);
      chk("sh_wdata_hi", last_wdata[31:16], 16'hABCD);
      chk("sh_rsp_data", last_data, 32'h0);
      mem_word[32'h0FC] = 32'hBBAA0000;
      mem_word[32'h100] = 32'h0000DDCC;
      send(1'b0, 3'b010, 32'h0FE, 32'h0); finish_txn();
`ifdef LSU_MISALIGNED_EN
      chk("lw_split_data", last_data, 32'hDDCCBBAA);
      chk("lw_split_beats", last_beats, 2);
`else
      chk("lw_misal_err", last_err, 1'b1);
      chk("lw_misal_beats", last_beats, 0);
`endif
      send(1'b0, 3'b011, 32'h200, 32'h0); finish_txn();
      chk("ld_err", last_err, 1'b1);
      chk("ld_beats", last_beats, 0);
      mem_mode = 2;
      send(1'b0, 3'b010, 32'h300, 32'h0);
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      #1;
      chk("abort_mem_valid", bus.mem_valid, 1'b0);
      chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
      chk("abort_mem_addr", bus.mem_addr, 32'h0);
      pending = 1'b0;
      mem_mode = 0;
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("abort_ready_after", bus.req_ready, 1'b1);
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         int r = $urandom_range(0, 2);
         a = r == 0 ? $urandom : r == 1 ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : ($urandom & 32'h3F);
         mem_mode = $urandom_range(0, 1);
         send(1'($urandom), 3'($urandom), a, $urandom);
         finish_txn();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 XLEN, 32, data/address width; SHALL be 32 or 64.
REQ-002 NB, XLEN/8, byte lanes per bus word; derived, SHALL NOT be overridden.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  request accepted when high with req_valid.
REQ-007 req_store  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RISC-V width/sign code.
REQ-009 req_addr  input  XLEN  byte address.
REQ-010 req_wdata  input  XLEN  store data, right-justified.
REQ-011 mem_valid  output  1  memory beat request.
REQ-012 mem_ready  input  1  memory beat complete; mem_rdata valid this cycle.
REQ-013 mem_we  output  1  beat is a write.
REQ-014 mem_addr  output  XLEN  word-aligned beat address (low log2(NB) bits zero).
REQ-015 mem_wdata  output  XLEN  lane-positioned write data.
REQ-016 mem_wmask  output  NB  byte-lane write enables; all zero on reads.
REQ-017 mem_rdata  input  XLEN  read data.
REQ-018 rsp_valid  output  1  one-cycle completion pulse.
REQ-019 rsp_data  output  XLEN  extended load result; zero for stores.
REQ-020 rsp_err  output  1  request rejected (qualified by rsp_valid).

Function
REQ-021 funct3: loads 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; stores 000-011; LD/LWU/SD legal only when XLEN=64; other codes SHALL set rsp_err.
REQ-022 FSM states IDLE, BEAT0, BEAT1, RESP; req_ready SHALL be high only in IDLE.
REQ-023 IDLE: on req_valid&&req_ready, latch request; go to BEAT0, or to RESP with rsp_err=1 and no memory beat if illegal.
REQ-024 BEAT0/BEAT1: mem_valid high and mem_addr/mem_we/mem_wdata/mem_wmask stable until mem_ready; mem_ready outside BEAT0/BEAT1 SHALL be ignored.
REQ-025 BEAT0 on mem_ready: go to BEAT1 if access crosses a word boundary ((addr mod NB)+size > NB), else RESP; BEAT1 on mem_ready: go to RESP; BEAT1 address = BEAT0 address + NB, wrapping modulo 2^XLEN.
REQ-026 RESP: rsp_valid=1 for exactly one cycle, then IDLE; aligned latency = 3 cycles accept-to-rsp with zero-wait memory, split = 4.
REQ-027 Stores: wdata shifted left by 8*(addr mod NB) into a 2*XLEN window with 2*NB mask; low half on BEAT0, high half on BEAT1.
REQ-028 Loads: BEAT0 data captured into window low half, BEAT1 into high half; result = window >> 8*(addr mod NB), truncated to size, sign-extended for LB/LH/LW, zero-extended for LBU/LHU/LWU.

Reset
REQ-029 reset low SHALL immediately force IDLE and drive req_ready=1, mem_valid=0, mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, rsp_err=0; an in-flight access SHALL be abandoned with no response.

Configuration
REQ-030 LSU_MISALIGNED_EN defined: misaligned accesses complete per REQ-025..028.
REQ-031 LSU_MISALIGNED_EN undefined: address not naturally aligned to size SHALL go IDLE->RESP with rsp_err=1 and no beat; FSM state BEAT1 and window high half SHALL NOT be built.

Structure
REQ-032 Package lsu_pkg SHALL hold the FSM state enum, funct3 constants and the size-decode function; one sub-module lsu_align (combinational shift, mask, extend) is instantiated by load_store_unit.

Verification (XLEN=32, zero-wait memory unless stated)
REQ-033 LW 0x100, mem_rdata 0xDEADBEEF -> one beat at 0x100, rsp_data 0xDEADBEEF, rsp_err 0, rsp_valid 3 cycles after accept.
REQ-034 LB 0x103, rdata 0x80112233 -> rsp_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-035 SH 0x102, wdata 0x0000ABCD -> mem_wmask 1100, mem_wdata[31:16]=0xABCD.
REQ-036 LSU_MISALIGNED_EN: LW 0x0FE, beats 0x0FC=0xBBAA0000, 0x100=0x0000DDCC -> rsp_data 0xDDCCBBAA; undefined -> rsp_err 1, no mem_valid.
REQ-037 LW with mem_ready delayed 5 cycles, reset low on cycle 3 -> mem_valid 0 same cycle, no rsp_valid, req_ready 1 after release; LD at XLEN=32 -> rsp_err 1.
